dm_ctrl: RTL and testbench

DM_CTRL -- requirements
Module: dm_ctrl

---
 rtl/dm_ctrl.sv | 123 ++++++++++++
 tb/tb_dm_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// Word-addressed RAM controller with a power-up/on-demand zero sweep, optional byte enables
// (macro DM_CTRL_BYTE_WRITE_EN) and registered read data one cycle after an accepted request.
module dm_ctrl #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            init,
  input  logic            re,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [31:0]     addr,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout,
  output logic            rvalid,
  output logic            busy,
  output logic            err
);

  localparam int NB  = DW / 8;
  localparam int OFS = $clog2(NB);
  localparam logic [31:0]   OFS_MASK = (32'd1 << OFS) - 32'd1;
  localparam logic [AW-1:0] PTR_LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [DW-1:0]   ram [2**AW];

  logic [AW-1:0]   idx;
  logic            misalign;
  logic            out_of_range;
  logic            req;
  logic            bad;
  logic            acc;
  logic [DW-1:0]   merged;
  logic [DW-1:0]   rd_word;
  logic            ram_we;
  logic [AW-1:0]   ram_wa;
  logic [DW-1:0]   ram_wd;

  assign idx          = addr[AW+OFS-1:OFS];
  assign misalign     = (addr & OFS_MASK) != 32'd0;
  assign out_of_range = (addr >> (AW + OFS)) != 32'd0;

  // A simultaneous init in IDLE takes precedence over any access in that cycle.
  assign req = (state == IDLE) && !init && (re || we);
  assign bad = req && (misalign || out_of_range);
  assign acc = req && !bad;

`ifdef DM_CTRL_BYTE_WRITE_EN
  always_comb begin
    merged = ram[idx];
    for (int k = 0; k < NB; k++) begin
      if (be[k]) merged[8*k +: 8] = din[8*k +: 8];
    end
  end
`else
  logic unused_be;
  assign unused_be = ^be;
  assign merged    = din;
`endif

  // Write-first: a read in the same cycle as a write returns the merged word.
  assign rd_word = we ? merged : ram[idx];

  // clr gating drops any write that coincides with reset.
  assign ram_we = !clr && ((state == CLEAR) || (acc && we));
  assign ram_wa = (state == CLEAR) ? ptr : idx;
  assign ram_wd = (state == CLEAR) ? '0 : merged;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= CLEAR;
      ptr    <= '0;
      dout   <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b1;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (init) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end else begin
            err <= bad;
            if (acc && re) begin
              dout   <= rd_word;
              rvalid <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (init) begin
            ptr <= '0;
          end else if (ptr == PTR_LAST) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl (DW=32, AW=4): directed scenarios plus randomized traffic against a word-array model.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        init = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        rvalid;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [16];
  logic [31:0] m_dout = 32'h0;
  logic        m_rv;
  logic        m_err;

  dm_ctrl #(.DW(32), .AW(4)) dut (
    .clk(clk), .clr(clr), .init(init), .re(re), .we(we), .be(be),
    .addr(addr), .din(din), .dout(dout), .rvalid(rvalid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  endfunction

  // Reference behaviour of one idle-state access.
  function automatic void model(input logic r, input logic w, input logic [3:0] b,
                                input logic [31:0] a, input logic [31:0] d);
    int i;
    m_rv  = 1'b0;
    m_err = 1'b0;
    if (!(r || w)) return;
    if ((a % 4) != 0 || a >= 32'd64) begin
      m_err = 1'b1;
      return;
    end
    i = a / 4;
    if (w) begin
`ifdef DM_CTRL_BYTE_WRITE_EN
      for (int k = 0; k < 4; k++) if (b[k]) mem[i][8*k +: 8] = d[8*k +: 8];
`else
      mem[i] = d;
`endif
    end
    if (r) begin
      m_dout = mem[i];
      m_rv   = 1'b1;
    end
  endfunction

  task automatic cycle(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    re = r; we = w; be = b; addr = a; din = d;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  task automatic access(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    cycle(r, w, b, a, d);
    model(r, w, b, a, d);
  endtask

  // Returns edges until busy is seen low, bounded.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    int n;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || dout !== 32'h0 || rvalid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: busy=%b dout=%h rvalid=%b err=%b, required 1/00000000/0/0",
               busy, dout, rvalid, err);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL reset_sweep_len: busy cycles=%0d, required 16", n);
    end
    model_clear();
    m_dout = 32'h0;
  endtask

  task automatic test_read_zero();
    access(1'b1, 1'b0, 4'h0, 32'h3C, 32'h0);
    checks++;
    if (dout !== 32'h0 || rvalid !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL read_after_sweep: dout=%h rvalid=%b err=%b, required 00000000/1/0", dout, rvalid, err);
    end
    @(posedge clk); #1;
    checks++;
    if (rvalid !== 1'b0 || dout !== 32'h0) begin
      failures++;
      $display("FAIL rvalid_single: rvalid=%b dout=%h, required 0/00000000", rvalid, dout);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] want;
`ifdef DM_CTRL_BYTE_WRITE_EN
    want = 32'hAABB11DD;
`else
    want = 32'h00001100;
`endif
    access(1'b0, 1'b1, 4'hF, 32'h08, 32'hAABBCCDD);
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL write_no_strobe: rvalid=%b err=%b, required 0/0", rvalid, err);
    end
    access(1'b0, 1'b1, 4'h2, 32'h08, 32'h00001100);
    access(1'b1, 1'b0, 4'h0, 32'h08, 32'h0);
    checks++;
    if (dout !== want || rvalid !== 1'b1) begin
      failures++;
      $display("FAIL byte_merge: dout=%h rvalid=%b, required %h/1", dout, rvalid, want);
    end
  endtask

  task automatic test_rw_same();
    access(1'b1, 1'b1, 4'hF, 32'h10, 32'h12345678);
    checks++;
    if (dout !== 32'h12345678 || rvalid !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL write_first: dout=%h rvalid=%b err=%b, required 12345678/1/0", dout, rvalid, err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] held;
    held = dout;
    access(1'b1, 1'b0, 4'h0, 32'h41, 32'h0);
    checks++;
    if (err !== 1'b1 || rvalid !== 1'b0 || dout !== held) begin
      failures++;
      $display("FAIL err_misaligned: err=%b rvalid=%b dout=%h, required 1/0/%h", err, rvalid, dout, held);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_one_cycle: err=%b, required 0", err);
    end
    access(1'b0, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF);
    checks++;
    if (err !== 1'b1 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL err_range: err=%b rvalid=%b, required 1/0", err, rvalid);
    end
    access(1'b1, 1'b0, 4'h0, 32'h00, 32'h0);
    checks++;
    if (dout !== 32'h0 || err !== 1'b0 || rvalid !== 1'b1) begin
      failures++;
      $display("FAIL ram0_untouched: dout=%h err=%b rvalid=%b, required 00000000/0/1", dout, err, rvalid);
    end
  endtask

  task automatic test_random(input int iters);
    logic r, w;
    logic [3:0] b;
    logic [31:0] a, d;
    for (int it = 0; it < iters; it++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      b = 4'($urandom);
      d = $urandom;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 15)) * 4;
      access(r, w, b, a, d);
      checks++;
      if (dout !== m_dout || rvalid !== m_rv || err !== m_err || (err && rvalid)) begin
        failures++;
        $display("FAIL random_%0d: r=%b w=%b a=%h dout=%h rv=%b err=%b, required %h/%b/%b",
                 it, r, w, a, dout, rvalid, err, m_dout, m_rv, m_err);
      end
    end
  endtask

  task automatic test_init_mid();
    int n;
    int bad_cnt;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL init_enter: busy=%b, required 1", busy);
    end
    repeat (7) begin @(posedge clk); #1; end
    init = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h04; din = 32'hDEADBEEF;
    @(posedge clk); #1;
    init = 1'b0;
    bad_cnt = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (i >= 10) we = 1'b0;
      @(posedge clk); #1;
      n++;
      if (rvalid || err) bad_cnt++;
      if (!busy) break;
    end
    we = 1'b0;
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL init_restart_len: busy cycles=%0d, required 16", n);
    end
    checks++;
    if (bad_cnt !== 0) begin
      failures++;
      $display("FAIL busy_ignores_access: strobe cycles=%0d, required 0", bad_cnt);
    end
    model_clear();
    access(1'b1, 1'b0, 4'h0, 32'h04, 32'h0);
    checks++;
    if (dout !== 32'h0 || rvalid !== 1'b1) begin
      failures++;
      $display("FAIL write_during_busy: dout=%h rvalid=%b, required 00000000/1", dout, rvalid);
    end
  endtask

  task automatic test_clr_mid();
    int n;
    access(1'b1, 1'b1, 4'hF, 32'h14, 32'h12345678);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (dout !== 32'h12345678 || busy !== 1'b1) begin
      failures++;
      $display("FAIL dout_hold_sweep: dout=%h busy=%b, required 12345678/1", dout, busy);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (dout !== 32'h0 || busy !== 1'b1 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL clr_mid_sweep: dout=%h busy=%b rvalid=%b, required 00000000/1/0", dout, busy, rvalid);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL clr_fresh_sweep: busy cycles=%0d, required 16", n);
    end
    model_clear();
    m_dout = 32'h0;
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_byte_write();
    test_rw_same();
    test_errors();
    test_random(300);
    test_init_mid();
    test_clr_mid();
    test_random(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
